// File: rtl/sysx_slave_endpoint_if.sv
// sysx_slave_endpoint_if: sysX v1 8-bit bus as seen between master controller and slave endpoint.
interface sysx_slave_endpoint_if;
    logic       iBusClock;
    logic [1:0] iBusSelect;
    logic [7:0] iBusMOSI;
    logic [7:0] oBusMISO;
    logic       oBusMISOEnable;
    logic       oBusInterrupt;
    modport master (output iBusClock, iBusSelect, iBusMOSI, input oBusMISO, oBusMISOEnable, oBusInterrupt);
    modport slave  (input iBusClock, iBusSelect, iBusMOSI, output oBusMISO, oBusMISOEnable, oBusInterrupt);
endinterface

// File: rtl/sysx_slave_endpoint.sv
// sysx_slave_endpoint: sysX v1 slave endpoint, deframes 6-beat word transfers into an RX FIFO and returns TX words on MISO.
// Optional saturating word/drop counters are enabled by defining SYSX_SLAVE_COUNTERS_EN.
module sysx_slave_endpoint #(
    parameter logic [1:0]  SLAVE_ID = 2'd1,
    parameter int          RX_DEPTH = 4,
    parameter logic [31:0] TX_IDLE  = 32'hFFFFFFFF
) (
    input  logic                 iClock,
    input  logic                 iReset,
    sysx_slave_endpoint_if.slave bus,
    input  logic                 iIntRequest,
    output logic [31:0]          oRxData,
    output logic                 oRxValid,
    input  logic                 iRxReady,
    input  logic [31:0]          iTxData,
    input  logic                 iTxValid,
    output logic                 oTxReady,
    input  logic                 iClearFlags,
    output logic                 oOverflow,
    output logic                 oUnderrun
`ifdef SYSX_SLAVE_COUNTERS_EN
    ,
    output logic [15:0]          oRxWordCount,
    output logic [15:0]          oDropCount
`endif
);
    localparam int AW = $clog2(RX_DEPTH);
    typedef enum logic [2:0] {IDLE, LOAD, B0, B1, B2, B3, STORE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  bclk_q;
    logic [1:0]  sel1_q, sel2_q;
    logic [7:0]  mosi1_q, mosi2_q;
    logic        en_q, int_q, hold_vld_q, ovf_q, und_q;
    logic [7:0]  miso_q, miso_d;
    logic [31:0] tx_q, rx_q, hold_q;
    logic [31:0] mem [RX_DEPTH];
    logic [AW:0] wp_q, rp_q;
    logic        rise, fall, sel, fetch, capture, push;
    logic        empty, full, pop, push_ok, ovf_set, und_set, accept, ovf_d, und_d;
    logic [1:0]  kd, kq;

    // Bus clock idles high, so its sync chain resets high to avoid a false edge.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            bclk_q  <= 3'b111;
            sel1_q  <= 2'd0;
            sel2_q  <= 2'd0;
            mosi1_q <= 8'd0;
            mosi2_q <= 8'd0;
        end else begin
            bclk_q  <= {bclk_q[1:0], bus.iBusClock};
            sel1_q  <= bus.iBusSelect;
            sel2_q  <= sel1_q;
            mosi1_q <= bus.iBusMOSI;
            mosi2_q <= mosi1_q;
        end
    end

    always_comb begin
        rise = bclk_q[1] && !bclk_q[2];
        fall = !bclk_q[1] && bclk_q[2];
        sel  = sel2_q == SLAVE_ID;
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // en_q is last cycle's sel, so IDLE only leaves on a genuine select rise.
    always_comb begin
        state_d = state_q;
        if (!sel)                  state_d = IDLE;
        else if (state_q == IDLE)  state_d = en_q ? IDLE : LOAD;
        else if (rise)             state_d = (state_q == STORE) ? LOAD : state_t'(state_q + 3'd1);
    end

    always_comb begin
        kd      = state_d[1:0] - 2'd2;
        kq      = state_q[1:0] - 2'd2;
        fetch   = (state_d == LOAD) && (state_q != LOAD);
        capture = fall && sel && (state_q inside {B0, B1, B2, B3});
        push    = fall && sel && (state_q == STORE);
        miso_d  = (state_d inside {B0, B1, B2, B3}) ? tx_q[{kd, 3'b000} +: 8] : 8'hFF;
    end

    // A full FIFO still accepts a push when the same cycle pops.
    always_comb begin
        empty   = wp_q == rp_q;
        full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        pop     = !empty && iRxReady;
        push_ok = push && (!full || pop);
        ovf_set = push && full && !pop;
        und_set = fetch && !hold_vld_q;
        accept  = iTxValid && !hold_vld_q;
        ovf_d   = ovf_set || (ovf_q && !iClearFlags);
        und_d   = und_set || (und_q && !iClearFlags);
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            en_q       <= 1'b0;
            int_q      <= 1'b0;
            miso_q     <= 8'hFF;
            tx_q       <= TX_IDLE;
            rx_q       <= 32'd0;
            hold_q     <= 32'd0;
            hold_vld_q <= 1'b0;
            wp_q       <= '0;
            rp_q       <= '0;
            ovf_q      <= 1'b0;
            und_q      <= 1'b0;
        end else begin
            en_q       <= sel;
            int_q      <= iIntRequest;
            miso_q     <= miso_d;
            hold_vld_q <= accept || (hold_vld_q && !fetch);
            ovf_q      <= ovf_d;
            und_q      <= und_d;
            if (fetch)   tx_q <= hold_vld_q ? hold_q : TX_IDLE;
            if (accept)  hold_q <= iTxData;
            if (capture) rx_q[{kq, 3'b000} +: 8] <= mosi2_q;
            if (push_ok) wp_q <= wp_q + (AW+1)'(1);
            if (pop)     rp_q <= rp_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge iClock) begin
        if (push_ok) mem[wp_q[AW-1:0]] <= rx_q;
    end

`ifdef SYSX_SLAVE_COUNTERS_EN
    logic [15:0] rxc_q, drc_q;
    logic        drop_inc;
    always_comb drop_inc = ovf_set || und_set;
    // A clear coinciding with an event leaves the count at one.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            rxc_q <= 16'd0;
            drc_q <= 16'd0;
        end else begin
            rxc_q <= iClearFlags ? {15'd0, push_ok} : (push_ok && rxc_q != 16'hFFFF) ? rxc_q + 16'd1 : rxc_q;
            drc_q <= iClearFlags ? {15'd0, drop_inc} : (drop_inc && drc_q != 16'hFFFF) ? drc_q + 16'd1 : drc_q;
        end
    end
    assign oRxWordCount = rxc_q;
    assign oDropCount   = drc_q;
`endif

    assign bus.oBusMISO       = miso_q;
    assign bus.oBusMISOEnable = en_q;
    assign bus.oBusInterrupt  = int_q;
    assign oRxValid           = !empty;
    assign oRxData            = empty ? 32'd0 : mem[rp_q[AW-1:0]];
    assign oTxReady           = !hold_vld_q;
    assign oOverflow          = ovf_q;
    assign oUnderrun          = und_q;
endmodule

// File: tb/tb_sysx_slave_endpoint.sv
// tb_sysx_slave_endpoint: directed sysX frames with scoreboard queues for RX words and MISO bytes.
module tb_sysx_slave_endpoint;
    localparam logic [1:0] SLAVE_ID = 2'd1;
    localparam int H = 80;

    logic        iClock, iReset, iIntRequest, iRxReady, iTxValid, iClearFlags;
    logic [31:0] iTxData, oRxData;
    logic        oRxValid, oTxReady, oOverflow, oUnderrun;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] exp_rx [$];
    logic [7:0]  exp_miso [$];
    logic [31:0] blk [5] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 32'h0BADF00D};

    sysx_slave_endpoint_if bus ();

    sysx_slave_endpoint #(.SLAVE_ID(SLAVE_ID), .RX_DEPTH(4), .TX_IDLE(32'hFFFFFFFF)) dut (
        .iClock(iClock), .iReset(iReset), .bus(bus.slave), .iIntRequest(iIntRequest),
        .oRxData(oRxData), .oRxValid(oRxValid), .iRxReady(iRxReady),
        .iTxData(iTxData), .iTxValid(iTxValid), .oTxReady(oTxReady),
        .iClearFlags(iClearFlags), .oOverflow(oOverflow), .oUnderrun(oUnderrun)
    );

    initial begin
        iClock = 0;
        forever #5 iClock = ~iClock;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge bus.iBusClock)
        if (exp_miso.size() > 0) chk("miso", {24'd0, bus.oBusMISO}, {24'd0, exp_miso.pop_front()});

    always @(negedge iClock)
        if (oRxValid && iRxReady) begin
            if (exp_rx.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rx_unexpected: got %h with no word expected", oRxData);
            end else chk("rx_data", oRxData, exp_rx.pop_front());
        end

    task automatic chk_reset();
        chk("rst_miso", {24'd0, bus.oBusMISO}, 32'hFF);
        chk("rst_en", {31'd0, bus.oBusMISOEnable}, 0);
        chk("rst_int", {31'd0, bus.oBusInterrupt}, 0);
        chk("rst_valid", {31'd0, oRxValid}, 0);
        chk("rst_data", oRxData, 0);
        chk("rst_txready", {31'd0, oTxReady}, 1);
        chk("rst_ovf", {31'd0, oOverflow}, 0);
        chk("rst_und", {31'd0, oUnderrun}, 0);
    endtask

    task automatic beat(input logic [7:0] mosi, input logic [7:0] miso);
        exp_miso.push_back(miso);
        bus.iBusClock = 0;
        #H;
        bus.iBusClock = 1;
        bus.iBusMOSI = mosi;
        #H;
    endtask

    task automatic start(input logic [1:0] s);
        bus.iBusSelect = s;
        #H;
        chk("miso_en", {31'd0, bus.oBusMISOEnable}, {31'd0, s == SLAVE_ID});
    endtask

    task automatic word_beats(input logic [31:0] w, input logic [31:0] tx, input logic first);
        if (!first) beat(8'hFF, 8'hFF);
        beat(w[7:0], 8'hFF);
        beat(w[15:8], tx[7:0]);
        beat(w[23:16], tx[15:8]);
        beat(w[31:24], tx[23:16]);
        beat(8'hFF, tx[31:24]);
    endtask

    task automatic finish_frame();
        exp_miso.push_back(8'hFF);
        bus.iBusClock = 0;
        #H;
        bus.iBusSelect = 0;
        #H;
        bus.iBusClock = 1;
        #H;
    endtask

    task automatic preload(input logic [31:0] w);
        @(negedge iClock);
        iTxData = w;
        iTxValid = 1;
        @(negedge iClock);
        iTxValid = 0;
        chk("preload_txready", {31'd0, oTxReady}, 0);
    endtask

    task automatic clear_flags();
        @(negedge iClock);
        iClearFlags = 1;
        @(negedge iClock);
        iClearFlags = 0;
        chk("clr_ovf", {31'd0, oOverflow}, 0);
        chk("clr_und", {31'd0, oUnderrun}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        iReset = 0; iIntRequest = 0; iRxReady = 1; iTxValid = 0; iTxData = 0; iClearFlags = 0;
        bus.iBusClock = 1; bus.iBusSelect = 0; bus.iBusMOSI = 0;
        #23;
        chk_reset();
        @(negedge iClock);
        iReset = 1;
        repeat (3) @(negedge iClock);
        iIntRequest = 1;
        repeat (2) @(negedge iClock);
        chk("interrupt", {31'd0, bus.oBusInterrupt}, 1);
        iIntRequest = 0;

        // single word, no TX pending
        exp_rx.push_back(32'h1BADC0DE);
        start(1);
        word_beats(32'h1BADC0DE, 32'hFFFFFFFF, 1);
        finish_frame();
        chk("single_und", {31'd0, oUnderrun}, 1);
        clear_flags();

        // transmit
        preload(32'hCAFEF00D);
        exp_rx.push_back(32'h12345678);
        start(1);
        chk("load_txready", {31'd0, oTxReady}, 1);
        word_beats(32'h12345678, 32'hCAFEF00D, 1);
        finish_frame();
        chk("tx_und", {31'd0, oUnderrun}, 0);

        // block of five with RX stalled
        iRxReady = 0;
        for (int i = 0; i < 4; i++) exp_rx.push_back(blk[i]);
        start(1);
        for (int i = 0; i < 5; i++) word_beats(blk[i], 32'hFFFFFFFF, i == 0);
        finish_frame();
        chk("blk_ovf", {31'd0, oOverflow}, 1);
        chk("blk_valid", {31'd0, oRxValid}, 1);
        iRxReady = 1;
        repeat (10) @(negedge iClock);
        chk("blk_drained", exp_rx.size(), 0);
        chk("blk_empty", {31'd0, oRxValid}, 0);
        clear_flags();

        // other device selected
        start(2);
        word_beats(32'hDEADBEEF, 32'hFFFFFFFF, 1);
        finish_frame();
        chk("other_valid", {31'd0, oRxValid}, 0);
        chk("other_und", {31'd0, oUnderrun}, 0);
        chk("other_en", {31'd0, bus.oBusMISOEnable}, 0);

        // select dropped after B1, then a full frame
        start(1);
        beat(8'hAA, 8'hFF);
        beat(8'hBB, 8'hFF);
        finish_frame();
        chk("partial_valid", {31'd0, oRxValid}, 0);
        exp_rx.push_back(32'h00000042);
        start(1);
        word_beats(32'h00000042, 32'hFFFFFFFF, 1);
        finish_frame();
        clear_flags();

        // reset mid-B2
        preload(32'h55AA33CC);
        start(1);
        beat(8'h01, 8'hFF);
        beat(8'h02, 8'hCC);
        beat(8'h03, 8'h33);
        chk("b2_miso", {24'd0, bus.oBusMISO}, 32'hAA);
        iReset = 0;
        #1;
        chk_reset();
        bus.iBusSelect = 0;
        #H;
        iReset = 1;
        #H;
        exp_rx.push_back(32'hA5A55A5A);
        start(1);
        word_beats(32'hA5A55A5A, 32'hFFFFFFFF, 1);
        finish_frame();
        repeat (5) @(negedge iClock);
        chk("end_rx_queue", exp_rx.size(), 0);
        chk("end_miso_queue", exp_miso.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
